// File: rtl/text_write_scheduler.sv
// Purpose: single owner of the text-mode character RAM write port; queues
//          character writes in a small FIFO and runs a full-screen clear engine.
// Latency: wr_req at edge N -> ram_we in the cycle after edge N+1 (continuous grant).
// Backpressure: writes issue only on edges that sample ram_grant=1; FIFO
//               overflow and out-of-range requests are discarded with wr_drop.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   wr_req/x/y/charattr  character write request (one-cycle pulse)
//   wr_full, wr_drop  queue full flag, request-discarded pulse
//   clear_req, clear_charattr  start a full-screen fill with the given value
//   busy              clear in progress
//   ram_grant         RAM write port free in the next cycle
//   ram_we/addr/data  registered RAM write port

`ifndef TEXTCOLS_CHAR
`define TEXTCOLS_CHAR 80
`endif
`ifndef TEXTROWS_CHAR
`define TEXTROWS_CHAR 30
`endif
`ifndef CHARATTR_RANGE
`define CHARATTR_RANGE 23:0
`endif

// Generic synchronous FIFO with a flush that may coincide with a push.
// Latency: a pushed word is visible at pop_dat after the push edge.
// Backpressure: caller must not push when full; pop on empty is ignored.
// DEPTH must be a power of two, at least 2.
module text_write_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

  // A flush rewinds both pointers, so a simultaneous push lands in slot 0.
  always_ff @(posedge clk) begin
    if (push) mem_q[flush ? '0 : wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= push ? AW'(1) : '0;
      count_q  <= push ? CW'(1) : '0;
    end else begin
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push)   wr_ptr_q <= wr_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(do_pop);
    end
  end
endmodule

module text_write_scheduler #(
  parameter int COLS       = `TEXTCOLS_CHAR,
  parameter int ROWS       = `TEXTROWS_CHAR,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [7:0]            wr_x,
  input  logic [7:0]            wr_y,
  input  logic [`CHARATTR_RANGE] wr_charattr,
  output logic                  wr_full,
  output logic                  wr_drop,
  input  logic                  clear_req,
  input  logic [`CHARATTR_RANGE] clear_charattr,
  output logic                  busy,
  input  logic                  ram_grant,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [`CHARATTR_RANGE] ram_data
);
  typedef logic [`CHARATTR_RANGE] charattr_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    charattr_t             data;
  } entry_t;
  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [CW-1:0]         DEPTH_C   = CW'(FIFO_DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  charattr_t             fill_q, fill_d;
  logic                  busy_q, busy_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  charattr_t             data_q, data_d;
  logic                  full_q, full_d;
  logic                  drop_q, drop_d;

  logic                  in_bounds;
  logic                  push, pop;
  entry_t                new_entry, head;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count, fifo_count_nxt;

  assign in_bounds = (int'(wr_x) < COLS) && (int'(wr_y) < ROWS);
  assign new_entry.addr = ADDR_WIDTH'(wr_y) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(wr_x);
  assign new_entry.data = wr_charattr;

  // The full check uses the registered flag, so a pop in the same cycle does
  // not rescue a request. A clear flushes first, which always leaves room.
  assign push = wr_req && in_bounds && (clear_req || !full_q);

  text_write_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (clear_req),
    .push     (push),
    .push_dat (new_entry),
    .pop      (pop),
    .pop_dat  (head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    fill_d    = fill_q;
    busy_d    = busy_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    pop       = 1'b0;
    drop_d    = wr_req && !push;

    if (clear_req) begin
      // Restart from cell 0 even mid-clear; no write issues on this edge.
      state_d   = CLEAR;
      clr_cnt_d = '0;
      fill_d    = clear_charattr;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (ram_grant) begin
            we_d   = 1'b1;
            addr_d = clr_cnt_q;
            data_d = fill_q;
            if (clr_cnt_q == LAST_ADDR) begin
              busy_d  = 1'b0;
              state_d = (!fifo_empty || push) ? DRAIN : IDLE;
            end else begin
              clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: begin
          if (ram_grant && !fifo_empty) begin
            pop    = 1'b1;
            we_d   = 1'b1;
            addr_d = head.addr;
            data_d = head.data;
          end
          state_d = (push || (fifo_count > CW'(pop))) ? DRAIN : IDLE;
        end
      endcase
    end

    if (clear_req) fifo_count_nxt = push ? CW'(1) : '0;
    else           fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);
    full_d = (fifo_count_nxt == DEPTH_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      fill_q    <= '0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      full_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      fill_q    <= fill_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      full_q    <= full_d;
      drop_q    <= drop_d;
    end
  end

  assign wr_full  = full_q;
  assign wr_drop  = drop_q;
  assign busy     = busy_q;
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;
endmodule

// File: doc/text_write_scheduler.md
# text_write_scheduler

Sequences all writes into the text-mode character RAM. Character writes from `i2c_slave_register` (`character_change`, `xtext`, `ytext`, `charattr`) are queued in a small FIFO. A built-in screen-clear engine fills every cell with one charattr value. Both sources share the single RAM write port and issue a write only in cycles the VGA fetch side grants.

## Interface
- `COLS`, default `` `TEXTCOLS_CHAR ``: characters per row.
- `ROWS`, default `` `TEXTROWS_CHAR ``: rows per screen.
- `ADDR_WIDTH`, default 12: RAM address width. Must satisfy COLS*ROWS ≤ 2^ADDR_WIDTH.
- `FIFO_DEPTH`, default 4: character-write queue depth, power of two.
- Width of `` `CHARATTR_RANGE `` is 24 bits: {attr2, attr1, char}.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `wr_req` in 1: one-cycle pulse requesting a character write.
- `wr_x` in 8: column of the write.
- `wr_y` in 8: row of the write.
- `wr_charattr` in `` `CHARATTR_RANGE ``: data for the write.
- `wr_full` out 1: FIFO full (registered).
- `wr_drop` out 1: one-cycle pulse when a write request is discarded.
- `clear_req` in 1: one-cycle pulse starting a full-screen clear.
- `clear_charattr` in `` `CHARATTR_RANGE ``: fill value for the clear.
- `busy` out 1: high while a clear is in progress.
- `ram_grant` in 1: the RAM write port is free in the next cycle.
- `ram_we` out 1: write enable to the RAM.
- `ram_addr` out ADDR_WIDTH: write address.
- `ram_data` out `` `CHARATTR_RANGE ``: write data.

## Operation
- Address arithmetic: ram_addr = wr_y*COLS + wr_x, computed in ADDR_WIDTH bits. The clear engine uses its own linear counter.
- Enqueue: on `wr_req`, the entry {addr, charattr} is pushed.
  - If wr_x ≥ COLS or wr_y ≥ ROWS, the request is discarded and `wr_drop` pulses.
  - If `wr_full` is 1, the request is discarded and `wr_drop` pulses. This holds even if a pop occurs in the same cycle.
- FSM has three states:
  - IDLE: FIFO empty, no clear pending. Goes to DRAIN when the FIFO is non-empty. Goes to CLEAR on `clear_req`.
  - DRAIN: on each cycle with `ram_grant`=1, pop the head entry and issue one write. Returns to IDLE when the last entry is popped and no entry is pushed in the same cycle. Goes to CLEAR on `clear_req`.
  - CLEAR: latch `clear_charattr`, set counter to 0, `busy`=1. On each granted cycle, write the counter value and increment it. After writing address COLS*ROWS-1, go to DRAIN if the FIFO is non-empty, otherwise to IDLE. `busy` falls on the same edge.
- `clear_req` in any state:
  - Flushes the FIFO. Entries queued earlier would be overwritten anyway.
  - Restarts the clear counter at 0 and latches the new fill value. This includes a `clear_req` arriving mid-clear.
- `wr_req` and `clear_req` in the same cycle: the flush happens first, then the write is enqueued. The write therefore lands after the clear completes.
- `wr_req` during CLEAR is queued normally, up to FIFO_DEPTH entries, and is drained after the clear.
- Ordering: FIFO writes reach RAM in arrival order. No write is ever reordered ahead of an earlier `clear_req`.

## Timing
- All outputs are registered.
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_data`=0, `busy`=0, `wr_full`=0, `wr_drop`=0, FIFO empty, state IDLE, clear counter 0.
- Write issue: `ram_grant` is sampled at edge N. If work is available, `ram_we`=1 with valid addr and data during cycle N+1. Otherwise `ram_we`=0. There is at most one write per grant.
- Enqueue latency: `wr_req` at edge N makes the entry eligible for the grant sampled at edge N+1. An empty FIFO with continuous grant gives `ram_we` in cycle N+2.
- `wr_full` and `wr_drop` update one edge after the causing event.
- Clear duration: exactly COLS*ROWS granted cycles. `busy` rises the edge after `clear_req` and falls on the edge that issues the last clear write.
- Reset asserted mid-operation: all state clears immediately, pending entries are lost, and `ram_we` drops asynchronously.

## Test plan
- Single write: wr_x=3, wr_y=2, charattr=24'h0F_07_41, `ram_grant` held 1. Expect one `ram_we` pulse with addr=2*COLS+3 and data 24'h0F0741, two cycles after `wr_req`.
- Back-pressure: 6 `wr_req` with `ram_grant`=0. Expect `wr_full`=1 after 4, `wr_drop` on requests 5 and 6. Then raise grant: exactly 4 writes, in order.
- Bounds: wr_x=COLS, wr_y=0. Expect `wr_drop` and no RAM write. Then x=COLS-1, y=ROWS-1 gives addr=COLS*ROWS-1.
- Clear: `clear_req` with fill 24'h00_07_20 and grant toggling 50%. Expect addresses 0..COLS*ROWS-1, each written once, in order. `busy` falls on the last write.
- Clear interaction: queue 2 writes with grant=0, then pulse `clear_req` and `wr_req` (x=5, y=0) in the same cycle. Expect the 2 earlier entries discarded, the full clear, then a single write to addr 5.
- Reset mid-clear: assert `reset` after 10 clear writes. Expect `ram_we`=0 and `busy`=0 immediately, and no further writes after release.
